// File: rtl/dwt_pkg.sv
// rtl/dwt_pkg.sv - shared constants and width helper for the multi-level Haar DWT.
package dwt_pkg;

  localparam logic MODE_SCALED = 1'b0;
  localparam logic MODE_LIFT   = 1'b1;

  localparam int W_DEFAULT = 8;
  localparam int DW        = W_DEFAULT + 1;

  function automatic int dw_of(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/haar_lift_stage.sv
// rtl/haar_lift_stage.sv - one Haar pair stage: holds half a, emits (s, d) one cycle after half b.
module haar_lift_stage
  import dwt_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         mode,
  input  logic         v_in,
  input  logic [W-1:0] x_in,
  output logic         v_out,
  output logic [W-1:0] s_out,
  output logic [W:0]   d_out
);

  localparam int XW = dw_of(W);

  logic          phase_q, phase_d;
  logic [W-1:0]  a_q, a_d;
  logic          v_q, v_d;
  logic [W-1:0]  s_q, s_d;
  logic [W:0]    d_q, d_d;

  logic              phase_eff;
  logic signed [XW-1:0] a_x, b_x, sum_x, dif_x, lift_s;

  always_comb begin
    a_x    = $signed({a_q[W-1], a_q});
    b_x    = $signed({x_in[W-1], x_in});
    sum_x  = a_x + b_x;
    dif_x  = a_x - b_x;
    lift_s = b_x + (dif_x >>> 1);

    // A frame start forces this cycle's input to be treated as a fresh half a.
    phase_eff = clr ? 1'b0 : phase_q;
    phase_d   = phase_eff;
    a_d       = clr ? '0 : a_q;
    v_d       = 1'b0;
    s_d       = s_q;
    d_d       = d_q;

    if (v_in) begin
      if (!phase_eff) begin
        a_d     = x_in;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        v_d     = 1'b1;
        if (mode == MODE_LIFT) begin
          d_d = dif_x;
          s_d = W'(lift_s);
        end else begin
          d_d = dif_x >>> 1;
          s_d = W'(sum_x >>> 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      a_q     <= '0;
      v_q     <= 1'b0;
      s_q     <= '0;
      d_q     <= '0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
      v_q     <= v_d;
      s_q     <= s_d;
      d_q     <= d_d;
    end
  end

  assign v_out = v_q;
  assign s_out = s_q;
  assign d_out = d_q;

endmodule

// File: rtl/haar_dwt_ml.sv
// rtl/haar_dwt_ml.sv - streaming multi-level Haar DWT: cascaded pair stages with per-frame mode.
module haar_dwt_ml
  import dwt_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int LEVELS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_frame_start,
  input  logic                     in_mode,
  input  logic [W-1:0]             in_data,
  output logic [LEVELS-1:0]        det_valid,
  output logic [LEVELS*(W+1)-1:0]  det_data,
  output logic                     approx_valid,
  output logic [W-1:0]             approx_data
);

  logic mode_q, mode_d;
  logic frame_start;

  logic [LEVELS-1:0] v_in;
  logic [LEVELS-1:0] v_out;
  logic [W-1:0]      x_in  [LEVELS];
  logic [W-1:0]      s_out [LEVELS];
  logic [W:0]        d_out [LEVELS];

  // The strobed sample already uses the new mode, hence mode_d rather than mode_q.
  always_comb begin
    frame_start = in_valid & in_frame_start;
    mode_d      = frame_start ? in_mode : mode_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_SCALED;
    end else begin
      mode_q <= mode_d;
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    if (k == 0) begin : g_head
      assign v_in[k] = in_valid;
      assign x_in[k] = in_data;
    end else begin : g_tail
      // Old-frame approximations still in flight are dropped at a frame start.
      assign v_in[k] = v_out[k-1] & ~frame_start;
      assign x_in[k] = s_out[k-1];
    end

    haar_lift_stage #(.W(W)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (frame_start),
      .mode  (mode_d),
      .v_in  (v_in[k]),
      .x_in  (x_in[k]),
      .v_out (v_out[k]),
      .s_out (s_out[k]),
      .d_out (d_out[k])
    );

    assign det_data[k*(W+1) +: W+1] = d_out[k];
  end

  assign det_valid    = v_out;
  assign approx_valid = v_out[LEVELS-1];
  assign approx_data  = s_out[LEVELS-1];

endmodule

// File: tb/tb_haar_dwt_ml.sv
// tb/tb_haar_dwt_ml.sv - self-checking bench for haar_dwt_ml (W=8, LEVELS=3).
module tb_haar_dwt_ml;

  localparam int W = 8;
  localparam int L = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_frame_start;
  logic             in_mode;
  logic [W-1:0]     in_data;
  logic [L-1:0]     det_valid;
  logic [L*(W+1)-1:0] det_data;
  logic             approx_valid;
  logic [W-1:0]     approx_data;

  haar_dwt_ml #(.W(W), .LEVELS(L)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_frame_start (in_frame_start),
    .in_mode        (in_mode),
    .in_data        (in_data),
    .det_valid      (det_valid),
    .det_data       (det_data),
    .approx_valid   (approx_valid),
    .approx_data    (approx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int s;
    int a;
    int b;
    bit md;
    int cyc;
  } exp_t;

  typedef struct {
    bit md;
    int a;
    int b;
    int d;
    int s;
  } vec_t;

  exp_t det_q [L][$];
  exp_t app_q [$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  int m_ph [L];
  int m_a  [L];
  bit m_mode;

  function automatic int sx9(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < L; k++) begin
      m_ph[k] = 0;
      m_a[k]  = 0;
      det_q[k].delete();
    end
    app_q.delete();
    m_mode = 1'b0;
  endtask

  task automatic model_push(input bit fs, input bit md, input int x);
    int   v;
    exp_t e;
    if (fs) begin
      m_mode = md;
      for (int k = 0; k < L; k++) m_ph[k] = 0;
    end
    v = x;
    for (int k = 0; k < L; k++) begin
      if (m_ph[k] == 0) begin
        m_a[k]  = v;
        m_ph[k] = 1;
        break;
      end
      m_ph[k] = 0;
      e.a   = m_a[k];
      e.b   = v;
      e.md  = m_mode;
      e.cyc = cyc + k + 1;
      if (m_mode) begin
        e.d = e.a - e.b;
        e.s = e.b + (e.d >>> 1);
      end else begin
        e.s = (e.a + e.b) >>> 1;
        e.d = (e.a - e.b) >>> 1;
      end
      det_q[k].push_back(e);
      if (k == L - 1) app_q.push_back(e);
      v = e.s;
    end
  endtask

  task automatic step(input bit v, input bit fs, input bit md, input int x);
    in_valid       = v;
    in_frame_start = fs;
    in_mode        = md;
    in_data        = x[W-1:0];
    if (v) model_push(fs, md, x);
    @(posedge clk);
    #1;
    cyc++;
    in_valid       = 1'b0;
    in_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < L; k++) begin
        if (det_valid[k]) begin
          if (det_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL det%0d_unexpected: got pulse at cycle %0d expected none", k, cyc);
          end else begin
            mon_e = det_q[k].pop_front();
            chk($sformatf("det%0d_data", k), sx9(det_data[k*(W+1) +: W+1]), mon_e.d);
            chk($sformatf("det%0d_cycle", k), cyc, mon_e.cyc);
            if (k == 0 && mon_e.md) begin
              chk("lift_recon_b0", sx8(dut.g_lvl[0].u_stage.s_out) - (sx9(det_data[8:0]) >>> 1), mon_e.b);
              chk("lift_recon_a0", sx9(det_data[8:0]) + sx8(dut.g_lvl[0].u_stage.s_out)
                  - (sx9(det_data[8:0]) >>> 1), mon_e.a);
            end
          end
        end else if (det_q[k].size() > 0 && det_q[k][0].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL det%0d_missed: got no pulse at cycle %0d expected %0d", k, cyc, det_q[k][0].d);
          void'(det_q[k].pop_front());
        end
      end
      if (approx_valid) begin
        if (app_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL approx_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          mon_e = app_q.pop_front();
          chk("approx_data", sx8(approx_data), mon_e.s);
          chk("approx_cycle", cyc, mon_e.cyc);
          if (mon_e.md) begin
            chk("lift_recon_bL", sx8(approx_data) - (sx9(det_data[L*(W+1)-1 -: W+1]) >>> 1), mon_e.b);
          end
        end
      end else if (app_q.size() > 0 && app_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL approx_missed: got no pulse at cycle %0d expected %0d", cyc, app_q[0].s);
        void'(app_q.pop_front());
      end
    end
  end

  vec_t vt [8];
  int   fr [8];

  initial begin
    vt[0] = '{1'b0,   10,    6,    2,    8};
    vt[1] = '{1'b0,   -3,    0,   -2,   -2};
    vt[2] = '{1'b1,   10,    6,    4,    8};
    vt[3] = '{1'b1,  127, -128,  255,   -1};
    vt[4] = '{1'b1,   -3,    0,   -3,   -2};
    vt[5] = '{1'b0,  127, -128,  127,   -1};
    vt[6] = '{1'b0, -128, -128,    0, -128};
    vt[7] = '{1'b1, -128,  127, -255,   -1};
    fr    = '{8, 8, 4, 4, 2, 2, 0, 0};

    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_frame_start = 1'b0;
    in_mode        = 1'b0;
    in_data        = '0;
    model_reset();
    #2;
    chk("reset_det_valid", int'(det_valid), 0);
    chk("reset_det_data", int'(det_data), 0);
    chk("reset_approx_valid", int'(approx_valid), 0);
    chk("reset_approx_data", int'(approx_data), 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc    = 0;
    mon_en = 1'b1;

    // Mid-stream reset: LIFT frame with a level-1 pulse live and half a held at level 0.
    step(1'b1, 1'b1, 1'b1, 10);
    step(1'b1, 1'b0, 1'b1, 6);
    step(1'b1, 1'b0, 1'b1, 30);
    step(1'b1, 1'b0, 1'b1, 2);
    step(1'b1, 1'b0, 1'b1, 50);
    mon_en = 1'b0;
    chk("pre_reset_det_valid", int'(det_valid), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_det_valid", int'(det_valid), 0);
    chk("async_reset_det_data", int'(det_data), 0);
    chk("async_reset_approx_valid", int'(approx_valid), 0);
    chk("async_reset_approx_data", int'(approx_data), 0);
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc    = 0;
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 1'b1, 3);
    chk("post_reset_valid", int'(det_valid[0]), 1);
    chk("post_reset_scaled_pair", sx9(det_data[8:0]), -1);
    idle(4);

    // Single-pair vectors, each in its own frame.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, vt[i].md, vt[i].a);
      step(1'b1, 1'b0, ~vt[i].md, vt[i].b);
      chk($sformatf("vec%0d_valid", i), int'(det_valid[0]), 1);
      chk($sformatf("vec%0d_det", i), sx9(det_data[8:0]), vt[i].d);
      chk($sformatf("vec%0d_approx", i), sx8(dut.g_lvl[0].u_stage.s_out), vt[i].s);
      idle(2);
    end

    // Full SCALED frame through all three levels.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, 1'b0, fr[i]);
      if (i == 4) begin
        chk("frame_det1_valid_c5", int'(det_valid[1]), 1);
        chk("frame_det1_c5", sx9(det_data[17:9]), 2);
      end
    end
    idle(1);
    chk("frame_det1_c9", sx9(det_data[17:9]), 1);
    idle(1);
    chk("frame_approx_valid_c10", int'(approx_valid), 1);
    chk("frame_approx_c10", sx8(approx_data), 3);
    chk("frame_det2_valid_c10", int'(det_valid[2]), 1);
    chk("frame_det2_c10", sx9(det_data[26:18]), 2);
    idle(2);

    // Frame start on an odd position; mode follows only the strobe.
    step(1'b1, 1'b1, 1'b1, 10);
    step(1'b1, 1'b0, 1'b0, 6);
    chk("odd_fs_lift_held", sx9(det_data[8:0]), 4);
    step(1'b1, 1'b0, 1'b0, 5);
    step(1'b1, 1'b1, 1'b0, 20);
    step(1'b1, 1'b0, 1'b1, 12);
    chk("odd_fs_new_pair_valid", int'(det_valid[0]), 1);
    chk("odd_fs_scaled_pair", sx9(det_data[8:0]), 4);
    step(1'b1, 1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 1'b0, 3);
    idle(6);

    // Random frames with idle gaps in both modes; frame 3 continues without a strobe.
    for (int f = 0; f < 6; f++) begin
      int n;
      idle(4);
      n = 8 * $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
        int x;
        int gap;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        idle(gap);
        x = $urandom_range(0, 255);
        x = x - 128;
        step(1'b1, (i == 0) && (f != 3), f[0] ^ (i != 0 && $urandom_range(0, 1) == 1), x);
      end
    end

    idle(8);
    chk("det_queues_drained", det_q[0].size() + det_q[1].size() + det_q[2].size(), 0);
    chk("approx_queue_drained", app_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
